// File: rtl/uart_aes_pkg.sv
// Shared constants and FSM state type for the UART AES-CTR host link.
package uart_aes_pkg;

  localparam int BLOCK_BYTES     = 16;
  localparam int BYTE_W          = 8;
  localparam int BLOCK_W         = 128;
  localparam int TX_GUARD_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    TX_BYTE,
    TX_WAIT,
    RX_COLLECT,
    DONE
  } link_state_t;

endpackage

// File: rtl/link_timeout_timer.sv
// Saturating idle-cycle counter; flags expiry once TIMEOUT_CYCLES idle cycles have elapsed.
module link_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_q;

  // Count run cycles since the last clear, holding at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (run && (count_q != LIMIT)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/uart_aes_host_link.sv
// Host-side initiator: serialises a 128-bit plaintext block MSB byte first into
// uart_tx, then gathers the 16 returned ciphertext bytes from uart_rx into one
// response, or reports a timeout if the far end goes quiet.
module uart_aes_host_link #(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int BLOCK_BYTES    = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [uart_aes_pkg::BLOCK_W-1:0]   req_block,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [uart_aes_pkg::BLOCK_W-1:0]   rsp_block,
  output logic                               rsp_timeout,
  output logic                               tx_trigger,
  output logic [uart_aes_pkg::BYTE_W-1:0]    tx_data,
  input  logic                               tx_busy,
  input  logic [uart_aes_pkg::BYTE_W-1:0]    rx_data,
  input  logic                               rx_valid,
  output logic                               stray_byte
);

  import uart_aes_pkg::*;

  localparam int IDX_W = $clog2(BLOCK_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);
  localparam int GUARD_W = $clog2(TX_GUARD_CYCLES + 1);
  localparam logic [GUARD_W-1:0] GUARD_DONE = GUARD_W'(TX_GUARD_CYCLES);

  link_state_t          state_q;
  logic [BLOCK_W-1:0]   shift_q;
  logic [IDX_W-1:0]     idx_q;
  logic [GUARD_W-1:0]   guard_q;
  logic                 rsp_valid_q;
  logic                 rsp_timeout_q;
  logic [BLOCK_W-1:0]   rsp_block_q;
  logic                 tx_trigger_q;
  logic [BYTE_W-1:0]    tx_data_q;
  logic                 stray_q;

  logic [BLOCK_W-1:0]   rx_shift_d;
  logic [BLOCK_W-1:0]   tx_shift_d;
  logic                 tmo_run;
  logic                 tmo_clear;
  logic                 tmo_expired;

  // Received bytes enter at the bottom so the first byte ends up in [127:120];
  // transmitted bytes leave from the top.
  assign rx_shift_d = {shift_q[BLOCK_W-BYTE_W-1:0], rx_data};
  assign tx_shift_d = {shift_q[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};

  // The idle timer only runs while collecting; any received byte restarts it,
  // which also makes a byte win over an expiry in the same cycle.
  assign tmo_run   = (state_q == RX_COLLECT);
  assign tmo_clear = !tmo_run || rx_valid;

  link_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear),
    .run     (tmo_run),
    .expired (tmo_expired)
  );

  // Link FSM: request intake, byte serialisation, response collection and hand-off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      idx_q         <= '0;
      guard_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_block_q   <= '0;
      tx_trigger_q  <= 1'b0;
      tx_data_q     <= '0;
      stray_q       <= 1'b0;
    end else begin
      tx_trigger_q <= 1'b0;
      stray_q      <= rx_valid && (state_q != RX_COLLECT);
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            shift_q <= req_block;
            idx_q   <= '0;
            state_q <= TX_BYTE;
          end
        end
        TX_BYTE: begin
          if (!tx_busy) begin
            tx_trigger_q <= 1'b1;
            tx_data_q    <= shift_q[BLOCK_W-1 -: BYTE_W];
            shift_q      <= tx_shift_d;
            guard_q      <= '0;
            state_q      <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          // Guard cycles give uart_tx time to raise busy before it is trusted.
          if (guard_q != GUARD_DONE) begin
            guard_q <= guard_q + GUARD_W'(1);
          end else if (!tx_busy) begin
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              shift_q <= '0;
              state_q <= RX_COLLECT;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= TX_BYTE;
            end
          end
        end
        RX_COLLECT: begin
          if (rx_valid) begin
            shift_q <= rx_shift_d;
            idx_q   <= idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
              rsp_block_q   <= rx_shift_d;
              rsp_timeout_q <= 1'b0;
              rsp_valid_q   <= 1'b1;
              idx_q         <= '0;
              state_q       <= DONE;
            end
          end else if (tmo_expired) begin
            rsp_block_q   <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            idx_q         <= '0;
            state_q       <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_block   = rsp_block_q;
  assign tx_trigger  = tx_trigger_q;
  assign tx_data     = tx_data_q;
  assign stray_byte  = stray_q;

endmodule

// File: doc/uart_aes_host_link.md
# uart_aes_host_link

Host-side initiator for the UART AES-CTR loopback protocol. It accepts a 128-bit plaintext block over a valid/ready port and serializes it as 16 bytes, MSB byte first, into a `uart_tx` instance. It then collects the 16 returned ciphertext bytes from a `uart_rx` instance and presents them as one 128-bit response, or reports a timeout. It sits between test/host logic and the `uart_tx`/`uart_rx` pair on the far end of the serial link.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 2_000_000: maximum idle clk cycles between response bytes (and before the first one) in RX_COLLECT.
- `BLOCK_BYTES`, default 16: bytes per block. Fixed; not meant to be overridden.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  plaintext block offered.
- `req_ready`  out  1  high only in IDLE.
- `req_block`  in  128  plaintext; byte 0 = [127:120].
- `rsp_valid`  out  1  response held until accepted.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_block`  out  128  ciphertext; first received byte = [127:120].
- `rsp_timeout`  out  1  qualifies `rsp_valid`; 1 = response aborted.
- `tx_trigger`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_data`  out  8  byte to `uart_tx`; valid with `tx_trigger`.
- `tx_busy`  in  1  from `uart_tx`.
- `rx_data`  in  8  from `uart_rx`.
- `rx_valid`  in  1  one-cycle byte strobe from `uart_rx`.
- `stray_byte`  out  1  one-cycle pulse when an `rx_valid` byte is discarded.

## Operation
- Reset values: state=IDLE; `req_ready`=1; `rsp_valid`=0; `rsp_timeout`=0; `rsp_block`=0; `tx_trigger`=0; `tx_data`=0; `stray_byte`=0; byte index=0; timeout count=0.
- A reset asserted mid-transfer aborts immediately. Bytes already triggered on `uart_tx` are not recalled.
- FSM states: IDLE, TX_BYTE, TX_WAIT, RX_COLLECT, DONE.
- IDLE: when `req_valid`, latch `req_block` into the shift register, set index=0, go to TX_BYTE.
- TX_BYTE: wait for `!tx_busy`. Then drive `tx_trigger`=1 and `tx_data`=shift[127:120], shift left by 8, go to TX_WAIT.
- TX_WAIT: hold for 2 guard cycles, which covers `uart_tx` raising busy. Then wait for `!tx_busy`.
  - If index==15: set index=0, clear the shift register and timeout count, go to RX_COLLECT.
  - Otherwise: index+1, go to TX_BYTE.
- RX_COLLECT: on `rx_valid`, shift left by 8 with `rx_data` in [7:0], index+1, clear the timeout count.
  - On the 16th byte: load `rsp_block`, `rsp_timeout`=0, `rsp_valid`=1, go to DONE.
  - Otherwise the timeout count increments each cycle. When it reaches `TIMEOUT_CYCLES`: `rsp_block`=0, `rsp_timeout`=1, `rsp_valid`=1, go to DONE.
  - If `rx_valid` arrives in the same cycle as the timeout is reached, the byte wins and the count clears.
- DONE: hold `rsp_*` stable until `rsp_ready`. Then clear `rsp_valid` and `rsp_timeout` and return to IDLE.
- `rx_valid` in IDLE, TX_BYTE, TX_WAIT or DONE: drop the byte and pulse `stray_byte` in the next cycle. The state is unaffected.
- Widths: index 4 bits. Timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates.

## Timing
- `req_ready` is combinational from state: it is 1 in the cycle the request is accepted.
- First `tx_trigger` is earliest 1 cycle after acceptance (TX_BYTE with `tx_busy`=0).
- The `tx_trigger` pulse is exactly 1 cycle. There is never more than one trigger per byte, and never a trigger while `tx_busy`=1.
- `rsp_valid` rises 1 cycle after the 16th `rx_valid`, or 1 cycle after the count reaches `TIMEOUT_CYCLES`.
- `rsp_valid` falls 1 cycle after the `rsp_valid & rsp_ready` cycle. The next request can be accepted in the cycle after that.
- Throughput: one block in flight. No pipelining.

## Structure
- Shared package `uart_aes_pkg`:
  - FSM enum `link_state_t`
  - `BLOCK_BYTES`=16
  - `BYTE_W`=8
  - `BLOCK_W`=128
  - `TX_GUARD_CYCLES`=2
- Sub-module `link_timeout_timer`:
  - Inputs: `clear`, `run`.
  - Output: `expired` when count == `TIMEOUT_CYCLES`.
  - Saturating counter; async active-high reset.
- Everything else stays flat in one FSM plus datapath.

## Test plan
- Basic round trip:
  - Stimulus: request 00112233445566778899aabbccddeeff. The responder model returns each byte XOR 0x5A, 20 cycles after each trigger.
  - Required: `tx_data` sequence 00,11,…,ff. `rsp_block` = 5a4b7869…a5, `rsp_timeout`=0.
- Busy stalls:
  - Stimulus: hold `tx_busy`=1 for 500 cycles per byte.
  - Required: exactly 16 triggers, none while busy, order preserved.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=100. Responder sends only 7 bytes.
  - Required: 100 cycles after the 7th byte, `rsp_valid`=1, `rsp_timeout`=1, `rsp_block`=0.
- Stray bytes and backpressure:
  - Stimulus: inject `rx_valid` in IDLE and during TX_WAIT. Hold `rsp_ready`=0 for 50 cycles.
  - Required: `stray_byte` pulses once per injected byte. The response is unaffected and held stable for 50 cycles.
- Reset mid-operation:
  - Stimulus: assert `reset` after the 5th trigger, then release.
  - Required: all outputs at reset values in the same cycle. The next request sends its byte 0 first.
- Byte/timeout collision:
  - Stimulus: `rx_valid` lands exactly when the count reaches `TIMEOUT_CYCLES`.
  - Required: no timeout; collection continues.
